demux_1to16_case: RTL and testbench
===================================

Name: demux_1to16_case

Overview:
- Registered 1-to-16 demultiplexer.
- Routes one `width`-bit input word to one of 16 output ports, chosen by a 4-bit select.
- All non-selected outputs are driven to zero.
- Used as a data-routing stage in the datapath. Outputs are registered: one clock of latency, clean glitch-free outputs.

Parameters:
- width, 8, data bit width of input and each output; legal range ≥4.
- snum, 4, select width; must equal 4 (16 outputs). Any other value is an elaboration error.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low. Clears all outputs.
- en  input  1  load enable. 1 = capture routing this cycle; 0 = hold all outputs.
- i  input  width  data word to route.
- sel  input  snum  destination index, 0..15.
- o0 … o15  output  width each  routed data outputs. oN carries i when sel==N, else 0.
- o_valid  output  16  one-hot flag; bit N set when oN holds a routed word.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n=0, any time, independent of clk):
  - o0..o15 = 0, o_valid = 16'h0000, immediately.
  - Reset asserted mid-operation discards the held word.
  - First capture occurs on the first rising clk edge with rst_n=1 and en=1.
- Rising clk edge, en=1:
  - oN ← i for N==sel; all other outputs ← 0.
  - o_valid ← 1<<sel.
  - Exactly one output is live.
- Rising clk edge, en=0: all outputs and o_valid hold.
- Latency: exactly 1 cycle from i/sel sampling to visible output. No combinational path from i/sel to outputs.
- sel change with en=1:
  - Previously selected output clears to 0 on the same edge the new output loads.
  - No cycle has two live outputs.
- Same sel on consecutive cycles: output updates to the new i each edge.
- i = 0 routed: oN = 0 but o_valid bit N = 1, which distinguishes "routed zero" from "not selected".
- sel is full-range (4 bits → 16 outputs), so no out-of-range case exists. Each sel value maps via a case statement; the default branch clears everything.
- X/Z on sel with en=1: all outputs and o_valid go to 0 (safe default).
- No handshake or backpressure; a new word is accepted every enabled cycle.

Decomposition:
- Shared package demux_pkg:
  - NUM_OUT = 16
  - SEL_W = 4
  - function onehot16(sel) returning a 16-bit one-hot.
- Sub-module demux_decoder_4to16: combinational sel → 16-bit one-hot.
  - Implemented with a case statement; default yields all-zero.
  - Top level uses it for both o_valid and per-output load gating.
- Top level holds 16 `width`-bit registers plus the o_valid register, with async-low reset.

Test Plan:
1. Reset: rst_n=0 with i=8'hFF, sel=4'd5, en=1 → all oN=0 and o_valid=0 during reset. After release and one edge → o5=8'hFF, others 0, o_valid=16'h0020.
2. Sweep, en=1, one sel per cycle:
   - sel=0..15 with i pattern 8'hA0, B0, C0, D0, E0, F0, A0, B0, A0, B0, C0, D0, E0, F0, A0, B0.
   - One edge after each: o[sel] equals that i, all other 15 outputs are 0, o_valid = 1<<sel.
3. Hold: load sel=4'd3, i=8'hD0, then en=0 with sel=4'd9, i=8'h11 for 3 cycles → o3 stays 8'hD0, o9=0, o_valid=16'h0008 throughout.
4. Latency / switchover: sel 4'd14 (i=8'hA0), then 4'd15 (i=8'hB0) on consecutive edges → o14 clears to 0 on the same edge o15 becomes 8'hB0. No cycle has o_valid with two bits set.
5. Zero routing: sel=4'd7, i=8'h00 → all outputs 0, o_valid=16'h0080.
6. Async reset mid-stream: assert rst_n=0 between clk edges while o12=8'hE0 → o12 and o_valid clear before the next clk edge.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-16 demultiplexer.
package demux_pkg;

    localparam int NUM_OUT = 16;
    localparam int SEL_W   = 4;

    function automatic logic [NUM_OUT-1:0] onehot16(input logic [SEL_W-1:0] sel);
        return NUM_OUT'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_decoder_4to16.sv
// Combinational 4-to-16 one-hot decoder; unknown selects decode to all-zero.
module demux_decoder_4to16
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]   sel_i,
    output logic [NUM_OUT-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        case (sel_i)
            4'd0:    onehot_o = 16'h0001;
            4'd1:    onehot_o = 16'h0002;
            4'd2:    onehot_o = 16'h0004;
            4'd3:    onehot_o = 16'h0008;
            4'd4:    onehot_o = 16'h0010;
            4'd5:    onehot_o = 16'h0020;
            4'd6:    onehot_o = 16'h0040;
            4'd7:    onehot_o = 16'h0080;
            4'd8:    onehot_o = 16'h0100;
            4'd9:    onehot_o = 16'h0200;
            4'd10:   onehot_o = 16'h0400;
            4'd11:   onehot_o = 16'h0800;
            4'd12:   onehot_o = 16'h1000;
            4'd13:   onehot_o = 16'h2000;
            4'd14:   onehot_o = 16'h4000;
            4'd15:   onehot_o = 16'h8000;
            // X/Z select falls through here so nothing goes live
            default: onehot_o = '0;
        endcase
    end

endmodule

// File: rtl/demux_1to16_case.sv
// Registered 1-to-16 demux: one cycle latency, exactly one live output per load.
// No handshake: a word is accepted on every rising edge with en high; en low holds everything.
module demux_1to16_case
    import demux_pkg::*;
#(
    parameter int width = 8,
    parameter int snum  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [width-1:0]   i,
    input  logic [snum-1:0]    sel,
    output logic [width-1:0]   o0,
    output logic [width-1:0]   o1,
    output logic [width-1:0]   o2,
    output logic [width-1:0]   o3,
    output logic [width-1:0]   o4,
    output logic [width-1:0]   o5,
    output logic [width-1:0]   o6,
    output logic [width-1:0]   o7,
    output logic [width-1:0]   o8,
    output logic [width-1:0]   o9,
    output logic [width-1:0]   o10,
    output logic [width-1:0]   o11,
    output logic [width-1:0]   o12,
    output logic [width-1:0]   o13,
    output logic [width-1:0]   o14,
    output logic [width-1:0]   o15,
    output logic [NUM_OUT-1:0] o_valid
);

    if (snum != SEL_W) begin : g_bad_snum
        $error("demux_1to16_case: snum must be 4");
    end

    logic [NUM_OUT-1:0] dec_onehot;
    logic [width-1:0]   data_q [NUM_OUT];
    logic [width-1:0]   data_d [NUM_OUT];
    logic [NUM_OUT-1:0] valid_q;
    logic [NUM_OUT-1:0] valid_d;

    demux_decoder_4to16 u_dec (
        .sel_i    (sel[SEL_W-1:0]),
        .onehot_o (dec_onehot)
    );

    // Loading clears every non-selected port in the same edge, so no two ports overlap.
    always_comb begin
        valid_d = valid_q;
        for (int n = 0; n < NUM_OUT; n++) begin
            data_d[n] = data_q[n];
        end
        if (en) begin
            valid_d = dec_onehot;
            for (int n = 0; n < NUM_OUT; n++) begin
                data_d[n] = dec_onehot[n] ? i : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int n = 0; n < NUM_OUT; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int n = 0; n < NUM_OUT; n++) begin
                data_q[n] <= data_d[n];
            end
        end
    end

    assign o_valid = valid_q;
    assign o0  = data_q[0];
    assign o1  = data_q[1];
    assign o2  = data_q[2];
    assign o3  = data_q[3];
    assign o4  = data_q[4];
    assign o5  = data_q[5];
    assign o6  = data_q[6];
    assign o7  = data_q[7];
    assign o8  = data_q[8];
    assign o9  = data_q[9];
    assign o10 = data_q[10];
    assign o11 = data_q[11];
    assign o12 = data_q[12];
    assign o13 = data_q[13];
    assign o14 = data_q[14];
    assign o15 = data_q[15];

endmodule

// File: tb/tb_demux_1to16_case.sv
// Bench for demux_1to16_case: directed scenarios plus random traffic against a port-array model.
module tb_demux_1to16_case;

    localparam int W = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         en = 1'b0;
    logic [W-1:0] i = '0;
    logic [3:0]   sel = '0;
    logic [W-1:0] o [16];
    logic [15:0]  o_valid;

    demux_1to16_case #(.width(W), .snum(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i), .sel(sel),
        .o0(o[0]), .o1(o[1]), .o2(o[2]), .o3(o[3]),
        .o4(o[4]), .o5(o[5]), .o6(o[6]), .o7(o[7]),
        .o8(o[8]), .o9(o[9]), .o10(o[10]), .o11(o[11]),
        .o12(o[12]), .o13(o[13]), .o14(o[14]), .o15(o[15]),
        .o_valid(o_valid)
    );

    // reference model: what each port holds, plus the port index that is live (-1 = none)
    logic [W-1:0] model_port [16];
    int           model_live;
    logic [15:0]  exp_q [$];

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 16; n++) model_port[n] = '0;
        model_live = -1;
    endtask

    task automatic model_load(input int s, input logic [W-1:0] d);
        model_clear();
        model_port[s] = d;
        model_live = s;
    endtask

    function automatic logic [15:0] model_valid();
        logic [15:0] v;
        v = '0;
        if (model_live >= 0) v[model_live] = 1'b1;
        return v;
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] want_v;
        want_v = exp_q.pop_front();
        for (int n = 0; n < 16; n++) begin
            check($sformatf("%s o%0d", tag, n), 32'(o[n]), 32'(model_port[n]));
        end
        check({tag, " o_valid"}, 32'(o_valid), 32'(want_v));
        check({tag, " onehot"}, 32'($countones(o_valid) <= 1), 32'(1));
    endtask

    // driver: apply inputs at negedge, let one rising edge happen, then sample at the next negedge
    task automatic step(input logic e, input logic [3:0] s, input logic [W-1:0] d, input string tag);
        en  = e;
        sel = s;
        i   = d;
        @(posedge clk);
        if (e) model_load(int'(s), d);
        exp_q.push_back(model_valid());
        @(negedge clk);
        check_all(tag);
    endtask

    logic [W-1:0] sweep_pat [16] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hA0, 8'hB0,
                                     8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hA0, 8'hB0};

    initial begin
        model_clear();

        // 1. reset held across edges with en high
        en = 1'b1; sel = 4'd5; i = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(16'h0000);
        check_all("reset");
        rst_n = 1'b1;
        step(1'b1, 4'd5, 8'hFF, "first_load");

        // 2. sweep all selects
        for (int s = 0; s < 16; s++) begin
            step(1'b1, 4'(s), sweep_pat[s], $sformatf("sweep%0d", s));
        end

        // 3. hold with en low
        step(1'b1, 4'd3, 8'hD0, "hold_load");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'd9, 8'h11, $sformatf("hold%0d", k));
        end

        // 4. switchover on consecutive edges
        step(1'b1, 4'd14, 8'hA0, "sw14");
        step(1'b1, 4'd15, 8'hB0, "sw15");
        check("sw o14 cleared", 32'(o[14]), 32'h0);

        // 5. routed zero
        step(1'b1, 4'd7, 8'h00, "zero");
        check("zero valid bit7", 32'(o_valid), 32'h0080);

        // 6. async reset between edges
        step(1'b1, 4'd12, 8'hE0, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        exp_q.push_back(16'h0000);
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'd12, 8'h5A, "post_rst");

        // random traffic
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 W'($urandom_range(0, 255)), $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
